ahb_param_arbiter: RTL



---
 rtl/ahb_param_arbiter.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/ahb_param_arbiter.sv
// ahb_param_arbiter
//   Parametrised AHB bus arbiter. It grants one of NUM_MASTERS requesters
//   ownership of the shared address/write-data path.
//   Two selection policies are available: fixed priority, where the lowest
//   index wins, or round-robin. The arbiter also supports bus locking and a
//   grant-hold timeout.
//
//   Every release goes through exactly one IDLE cycle with all grants low.
//   timeout_pulse and err_pulse are registered, so each one is high during
//   the first IDLE cycle that follows the release it reports.
//
// Ports
//   hclk, hresetn   clock (rising edge), asynchronous active-low reset
//   hreq[N]         per-master bus request
//   hlock[N]        per-master lock; the owner keeps the bus across completions
//   sel_in[N*SEL_W] per-master slave select, master i at [i*SEL_W +: SEL_W]
//   hready_out      ready from the selected slave
//   hresp           response from the selected slave (1 = error)
//   hgrant[N]       one-hot grant (registered)
//   sel[SEL_W]      slave select captured at grant entry (registered)
//   hmaster[MIDX_W] index of the current owner (registered)
//   busy            high while a grant is active
//   timeout_pulse   one-cycle pulse after a MAX_HOLD forced release
//   err_pulse       one-cycle pulse after an error completion
module ahb_param_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int SEL_W       = 2,
  parameter int RR_MODE     = 1,
  parameter int MAX_HOLD    = 16,
  parameter int MIDX_W      = 2
) (
  input  logic                         hclk,
  input  logic                         hresetn,
  input  logic [NUM_MASTERS-1:0]       hreq,
  input  logic [NUM_MASTERS-1:0]       hlock,
  input  logic [NUM_MASTERS*SEL_W-1:0] sel_in,
  input  logic                         hready_out,
  input  logic                         hresp,
  output logic [NUM_MASTERS-1:0]       hgrant,
  output logic [SEL_W-1:0]             sel,
  output logic [MIDX_W-1:0]            hmaster,
  output logic                         busy,
  output logic                         timeout_pulse,
  output logic                         err_pulse
);

  localparam int HCNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HCNT_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HCNT_W'(MAX_HOLD - 1) : '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1
  } state_t;

  state_t                   state, state_n;
  logic [NUM_MASTERS-1:0]   hgrant_n;
  logic [SEL_W-1:0]         sel_n;
  logic [MIDX_W-1:0]        hmaster_n;
  logic                     busy_n;
  logic                     timeout_pulse_n;
  logic                     err_pulse_n;
  logic [HCNT_W-1:0]        hold_cnt, hold_cnt_n;
  logic [MIDX_W-1:0]        rr_ptr, rr_ptr_n;

  logic                     tr_done;
  logic                     err_done;
  logic                     timeout_hit;
  logic                     owner_lock;
  logic [NUM_MASTERS-1:0]   lock_sh;
  logic [MIDX_W-1:0]        win;
  logic                     any_req;
  logic [NUM_MASTERS*SEL_W-1:0] sel_sh;
  logic [SEL_W-1:0]         sel_win;

  assign tr_done  = hready_out & ~hresp;
  assign err_done = hready_out & hresp;

  // Shifts rather than variable bit-selects keep index widths independent of
  // NUM_MASTERS.
  assign lock_sh    = hlock >> hmaster;
  assign owner_lock = lock_sh[0];
  assign sel_sh     = sel_in >> (32'(win) * SEL_W);
  assign sel_win    = sel_sh[SEL_W-1:0];

  assign timeout_hit = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST) && !tr_done;

  // The round-robin search starts one past the last winner, wrapping modulo
  // NUM_MASTERS. Fixed priority scans upward from index 0.
  always_comb begin
    int unsigned            idx;
    logic [NUM_MASTERS-1:0] req_sh;
    win     = '0;
    any_req = 1'b0;
    idx     = 0;
    req_sh  = '0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      if (RR_MODE != 0) idx = (32'(rr_ptr) + k + 1) % NUM_MASTERS;
      else              idx = k;
      req_sh = hreq >> idx;
      if (!any_req && req_sh[0]) begin
        any_req = 1'b1;
        win     = MIDX_W'(idx);
      end
    end
  end

  always_comb begin
    state_n         = state;
    hgrant_n        = hgrant;
    sel_n           = sel;
    hmaster_n       = hmaster;
    busy_n          = busy;
    timeout_pulse_n = 1'b0;
    err_pulse_n     = 1'b0;
    hold_cnt_n      = hold_cnt;
    rr_ptr_n        = rr_ptr;
    case (state)
      IDLE: begin
        hgrant_n = '0;
        busy_n   = 1'b0;
        if (any_req) begin
          state_n    = GRANT;
          hgrant_n   = NUM_MASTERS'(1) << win;
          hmaster_n  = win;
          sel_n      = sel_win;
          busy_n     = 1'b1;
          hold_cnt_n = '0;
          rr_ptr_n   = win;
        end
      end
      GRANT: begin
        if (timeout_hit) begin
          state_n         = IDLE;
          hgrant_n        = '0;
          busy_n          = 1'b0;
          timeout_pulse_n = 1'b1;
        end else if (err_done) begin
          state_n     = IDLE;
          hgrant_n    = '0;
          busy_n      = 1'b0;
          err_pulse_n = 1'b1;
        end else if (tr_done && owner_lock) begin
          hold_cnt_n = '0;
        end else if (tr_done) begin
          state_n  = IDLE;
          hgrant_n = '0;
          busy_n   = 1'b0;
        end else if (hold_cnt != '1) begin
          hold_cnt_n = hold_cnt + 1'b1;
        end
      end
      default: begin
        state_n  = IDLE;
        hgrant_n = '0;
        busy_n   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state         <= IDLE;
      hgrant        <= '0;
      sel           <= '0;
      hmaster       <= '0;
      busy          <= 1'b0;
      timeout_pulse <= 1'b0;
      err_pulse     <= 1'b0;
      hold_cnt      <= '0;
      rr_ptr        <= MIDX_W'(NUM_MASTERS - 1);
    end else begin
      state         <= state_n;
      hgrant        <= hgrant_n;
      sel           <= sel_n;
      hmaster       <= hmaster_n;
      busy          <= busy_n;
      timeout_pulse <= timeout_pulse_n;
      err_pulse     <= err_pulse_n;
      hold_cnt      <= hold_cnt_n;
      rr_ptr        <= rr_ptr_n;
    end
  end

endmodule
